exe_issue_sequencer: RTL and testbench
======================================

Name: exe_issue_sequencer

Overview:
- Sits between decode and the execute datapath.
- Accepts one decoded op per handshake and lets single-cycle ALU ops through with one cycle of latency.
- Sequences multi-cycle M-extension ops (is_mul) on an external iterative M-unit through a start/done handshake, and holds issue while that unit is busy.
- Owns the single-entry result slot feeding writeback, and handles pipeline flush and M-unit timeout.

Parameters:
- ARCH_LEN, 32, datapath width (from constants_pkg).
- REG_ADDR_W, 5, destination register index width.
- M_TIMEOUT, 64, max cycles to wait for m_done before aborting; must be ≥ 2.
- CNT_W, 7, width of the M-op cycle counter; must satisfy 2^CNT_W > M_TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  kill in-flight op and result slot (branch mispredict/trap).
- in_valid  in  1  decode presents an op.
- in_ready  out  1  sequencer can accept.
- in_is_mul  in  1  op goes to the M-unit.
- in_func3  in  3  op func3.
- in_op1  in  ARCH_LEN  operand 1.
- in_op2  in  ARCH_LEN  operand 2 (immediate already muxed).
- in_dst  in  REG_ADDR_W  destination register.
- alu_result  in  ARCH_LEN  combinational ALU result for the current in_* op.
- m_start  out  1  one-cycle start pulse to the M-unit.
- m_kill  out  1  one-cycle abort pulse to the M-unit.
- m_op1, m_op2  out  ARCH_LEN each  latched operands, stable throughout M_WAIT.
- m_func3  out  3  latched func3.
- m_done  in  1  M-unit result valid (single-cycle pulse).
- m_result  in  ARCH_LEN  M-unit result.
- out_valid  out  1  result slot full.
- out_ready  in  1  writeback consumes the slot.
- out_data  out  ARCH_LEN  result.
- out_dst  out  REG_ADDR_W  result destination.
- busy  out  1  state != IDLE.
- m_timeout_err  out  1  sticky; set on M-unit timeout.

Behaviour:
- States: IDLE, M_WAIT.
- Reset values:
  - state = IDLE.
  - out_valid, m_start, m_kill, m_timeout_err, busy = 0.
  - out_data, out_dst, m_op1, m_op2, m_func3, counter = 0.
- in_ready = (state == IDLE) & (!out_valid | out_ready) & !flush. It is combinational.
- Accept = in_valid & in_ready.
- Slot drain (out_valid & out_ready) clears out_valid next cycle, unless a new result loads the slot in the same cycle. A new result wins.
- ALU op (accept, !in_is_mul), accepted in cycle N:
  - alu_result and in_dst are registered into the slot.
  - out_valid = 1 from N+1.
  - State stays IDLE, giving back-to-back throughput of 1/cycle when out_ready = 1.
- M op (accept, in_is_mul), accepted in cycle N:
  - in_op1, in_op2, in_func3 and in_dst are latched.
  - Go to M_WAIT. m_start = 1 in cycle N+1 only.
  - Counter is cleared at accept and increments each M_WAIT cycle.
- M_WAIT:
  - m_done in cycle K loads m_result and the latched dst into the slot; out_valid = 1 from K+1; state returns to IDLE at K+1.
  - m_done in the same cycle as m_start is legal and is honoured.
  - out_valid is always 0 in M_WAIT. This is an invariant: a mul is only accepted when the slot is empty or draining.
- Timeout: in M_WAIT, when counter == M_TIMEOUT with no m_done:
  - m_kill pulses 1 cycle.
  - m_timeout_err is set (sticky until rst).
  - state returns to IDLE; no result is written.
  - m_done in the timeout cycle takes priority (result captured, no error).
- m_done outside M_WAIT is ignored.
- flush (priority below rst, above everything else):
  - Next cycle: state = IDLE, out_valid = 0, counter = 0.
  - m_kill = 1 in the next cycle if flush arrived in M_WAIT.
  - A pending m_start for that op is suppressed.
  - in_ready = 0 during the flush cycle.
  - m_done coincident with flush is discarded.
- rst mid-M_WAIT: all outputs return to reset values. No m_kill is generated; the M-unit receives the same rst.
- Data is not width-extended; all paths are ARCH_LEN wide.

Test Plan:
- ALU streaming: three ALU ops with alu_result 0x11, 0x22, 0x33, out_ready = 1 → out_valid high for 3 consecutive cycles, each output one cycle after its accept, in_ready never drops.
- Backpressure: ALU op 0xAA with out_ready = 0 for 4 cycles → in_ready = 0 while the slot is full; out_data holds 0xAA; drains on out_ready = 1; the next op is accepted in the same cycle.
- Mul sequencing: mul with op1 = 6, op2 = 7, dst = 5; M-unit returns 42 three cycles after m_start → m_start exactly one pulse, m_op1 = 6 and m_op2 = 7 stable, busy = 1, out_data = 42 and out_dst = 5 one cycle after m_done, in_ready = 0 throughout.
- Timeout: mul with M_TIMEOUT = 4 and m_done never asserted → m_kill pulse when the counter reaches 4, m_timeout_err = 1 and stays set, state IDLE, out_valid = 0.
- Flush: flush during M_WAIT, with m_done in the following cycle → m_kill pulse, out_valid stays 0, the late m_done is ignored. Flush with the slot full → out_valid cleared.
- Reset mid-op: rst asserted in M_WAIT → the next cycle has all outputs at reset values, and a fresh ALU op then completes normally.

Source files
------------

// File: rtl/exe_issue_sequencer.sv
// rtl/exe_issue_sequencer.sv - issue sequencer between decode and execute
//
// Passes single-cycle ALU ops into a one-entry result slot with one cycle of
// latency, and runs multi-cycle M ops on an external iterative M-unit via a
// start/done handshake with a cycle-bounded wait.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               kill in-flight op and result slot
//   in_valid/in_ready   decode handshake; in_is_mul, in_func3, in_op1, in_op2,
//                       in_dst describe the op, alu_result is its ALU value
//   m_start, m_kill     one-cycle start / abort pulses to the M-unit
//   m_op1, m_op2,
//   m_func3             latched M-op operands, stable during M_WAIT
//   m_done, m_result    M-unit completion pulse and result
//   out_valid/out_ready result slot handshake; out_data, out_dst payload
//   busy                M op outstanding
//   m_timeout_err       sticky M-unit timeout flag
module exe_issue_sequencer #(
   parameter int ARCH_LEN   = 32,
   parameter int REG_ADDR_W = 5,
   parameter int M_TIMEOUT  = 64,
   parameter int CNT_W      = 7
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_is_mul,
   input  logic [2:0]            in_func3,
   input  logic [ARCH_LEN-1:0]   in_op1,
   input  logic [ARCH_LEN-1:0]   in_op2,
   input  logic [REG_ADDR_W-1:0] in_dst,
   input  logic [ARCH_LEN-1:0]   alu_result,
   output logic                  m_start,
   output logic                  m_kill,
   output logic [ARCH_LEN-1:0]   m_op1,
   output logic [ARCH_LEN-1:0]   m_op2,
   output logic [2:0]            m_func3,
   input  logic                  m_done,
   input  logic [ARCH_LEN-1:0]   m_result,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ARCH_LEN-1:0]   out_data,
   output logic [REG_ADDR_W-1:0] out_dst,
   output logic                  busy,
   output logic                  m_timeout_err
);

   typedef enum logic [0:0] {IDLE, M_WAIT} state_t;

   state_t                  state, state_nxt;
   logic [CNT_W-1:0]        counter;
   logic [REG_ADDR_W-1:0]   m_dst;
   logic                    start_q;
   logic                    accept;
   logic                    load_alu, load_mul, done_hit, timeout_hit;
   logic                    start_nxt, kill_nxt;

   // A mul is only accepted when the slot is empty or draining, so the slot
   // is never occupied while the M-unit is running.
   assign in_ready = (state == IDLE) && (!out_valid || out_ready) && !flush;
   assign accept   = in_valid && in_ready;
   assign busy     = (state != IDLE);
   // A flush in the start cycle withdraws the start pulse for the dying op.
   assign m_start  = start_q && !flush;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      load_alu    = 1'b0;
      load_mul    = 1'b0;
      done_hit    = 1'b0;
      timeout_hit = 1'b0;
      start_nxt   = 1'b0;
      kill_nxt    = 1'b0;
      case (state)
         IDLE: begin
            load_alu  = accept && !in_is_mul;
            load_mul  = accept && in_is_mul;
            start_nxt = load_mul;
            if (load_mul) state_nxt = M_WAIT;
         end
         M_WAIT: begin
            if (flush) begin
               kill_nxt  = 1'b1;
               state_nxt = IDLE;
            end else if (m_done) begin
               // done wins over a timeout landing in the same cycle
               done_hit  = 1'b1;
               state_nxt = IDLE;
            end else if (counter == CNT_W'(M_TIMEOUT)) begin
               timeout_hit = 1'b1;
               kill_nxt    = 1'b1;
               state_nxt   = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         start_q       <= 1'b0;
         m_kill        <= 1'b0;
         m_timeout_err <= 1'b0;
         counter       <= '0;
         m_op1         <= '0;
         m_op2         <= '0;
         m_func3       <= '0;
         m_dst         <= '0;
         out_valid     <= 1'b0;
         out_data      <= '0;
         out_dst       <= '0;
      end else begin
         start_q <= start_nxt;
         m_kill  <= kill_nxt;
         if (timeout_hit) m_timeout_err <= 1'b1;

         if (flush || accept)      counter <= '0;
         else if (state == M_WAIT) counter <= counter + CNT_W'(1);

         if (load_mul) begin
            m_op1   <= in_op1;
            m_op2   <= in_op2;
            m_func3 <= in_func3;
            m_dst   <= in_dst;
         end

         // A new result takes priority over a same-cycle drain.
         if (flush) begin
            out_valid <= 1'b0;
         end else if (load_alu) begin
            out_valid <= 1'b1;
            out_data  <= alu_result;
            out_dst   <= in_dst;
         end else if (done_hit) begin
            out_valid <= 1'b1;
            out_data  <= m_result;
            out_dst   <= m_dst;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_exe_issue_sequencer.sv
// tb/tb_exe_issue_sequencer.sv - self-checking bench for exe_issue_sequencer
module tb_exe_issue_sequencer;

   localparam int AL = 32;
   localparam int RW = 5;
   localparam int T  = 4;

   logic          clk = 1'b0;
   logic          rst, flush, in_valid, in_is_mul, m_done, out_ready;
   logic [2:0]    in_func3;
   logic [AL-1:0] in_op1, in_op2, alu_result, m_result;
   logic [RW-1:0] in_dst;
   logic          in_ready, m_start, m_kill, out_valid, busy, m_timeout_err;
   logic [AL-1:0] m_op1, m_op2, out_data;
   logic [2:0]    m_func3;
   logic [RW-1:0] out_dst;

   exe_issue_sequencer #(.ARCH_LEN(AL), .REG_ADDR_W(RW), .M_TIMEOUT(T), .CNT_W(3)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_is_mul(in_is_mul), .in_func3(in_func3), .in_op1(in_op1), .in_op2(in_op2),
      .in_dst(in_dst), .alu_result(alu_result), .m_start(m_start), .m_kill(m_kill),
      .m_op1(m_op1), .m_op2(m_op2), .m_func3(m_func3), .m_done(m_done),
      .m_result(m_result), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_dst(out_dst), .busy(busy), .m_timeout_err(m_timeout_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Reference state: what the slot holds, whether a mul is outstanding and
   // how many cycles it has been waiting (1 = first wait cycle).
   bit          e_valid, e_mwait, e_start, e_kill, e_err;
   int          e_age;
   logic [AL-1:0] e_data, e_op1, e_op2;
   logic [RW-1:0] e_dst, e_mdst;
   logic [2:0]    e_f3;

   task automatic assert_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
      end
   endtask

   function automatic bit exp_ready();
      return !e_mwait && (!e_valid || out_ready) && !flush;
   endfunction

   task automatic model_reset();
      e_valid = 0; e_mwait = 0; e_start = 0; e_kill = 0; e_err = 0; e_age = 0;
      e_data = '0; e_op1 = '0; e_op2 = '0; e_dst = '0; e_mdst = '0; e_f3 = '0;
   endtask

   task automatic model_step();
      bit acc;
      acc = in_valid && exp_ready();
      if (rst) begin
         model_reset();
         return;
      end
      e_start = 0;
      e_kill  = 0;
      if (flush) begin
         e_kill  = e_mwait;
         e_mwait = 0;
         e_valid = 0;
         e_age   = 0;
      end else if (e_mwait) begin
         if (m_done) begin
            e_valid = 1; e_data = m_result; e_dst = e_mdst; e_mwait = 0;
         end else if (e_age == T + 1) begin
            e_kill = 1; e_err = 1; e_mwait = 0;
         end else begin
            e_age++;
         end
      end else if (acc && in_is_mul) begin
         e_op1 = in_op1; e_op2 = in_op2; e_f3 = in_func3; e_mdst = in_dst;
         e_mwait = 1; e_age = 1; e_start = 1; e_valid = 0;
      end else if (acc) begin
         e_valid = 1; e_data = alu_result; e_dst = in_dst;
      end else if (e_valid && out_ready) begin
         e_valid = 0;
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      assert_eq("in_ready",  32'(in_ready),      32'(exp_ready()));
      assert_eq("out_valid", 32'(out_valid),     32'(e_valid));
      assert_eq("out_data",  out_data,           e_data);
      assert_eq("out_dst",   32'(out_dst),       32'(e_dst));
      assert_eq("m_start",   32'(m_start),       32'(e_start && !flush));
      assert_eq("m_kill",    32'(m_kill),        32'(e_kill));
      assert_eq("busy",      32'(busy),          32'(e_mwait));
      assert_eq("m_err",     32'(m_timeout_err), 32'(e_err));
      assert_eq("m_op1",     m_op1,              e_op1);
      assert_eq("m_op2",     m_op2,              e_op2);
      assert_eq("m_func3",   32'(m_func3),       32'(e_f3));
      @(posedge clk);
      model_step();
      cyc++;
      #1;
   endtask

   task automatic quiet();
      rst = 0; flush = 0; in_valid = 0; in_is_mul = 0; m_done = 0;
   endtask

   task automatic op(input bit mul, input logic [AL-1:0] a, input logic [AL-1:0] b,
                     input logic [RW-1:0] d, input logic [AL-1:0] r);
      in_valid = 1; in_is_mul = mul; in_op1 = a; in_op2 = b; in_dst = d;
      alu_result = r; in_func3 = 3'd0;
   endtask

   initial begin
      quiet();
      rst = 1; out_ready = 1; in_func3 = 0; in_op1 = 0; in_op2 = 0; in_dst = 0;
      alu_result = 0; m_result = 0;
      repeat (2) @(posedge clk);
      model_reset();
      #1;
      quiet();

      // ALU streaming
      op(0, 0, 0, 5'd1, 32'h11); cycle();
      op(0, 0, 0, 5'd2, 32'h22); cycle();
      op(0, 0, 0, 5'd3, 32'h33); cycle();
      quiet(); repeat (2) cycle();

      // Backpressure
      out_ready = 0;
      op(0, 0, 0, 5'd4, 32'hAA); cycle();
      op(0, 0, 0, 5'd6, 32'hBB); repeat (4) cycle();
      out_ready = 1; cycle();
      quiet(); repeat (2) cycle();

      // Mul with done three cycles after m_start
      op(1, 32'd6, 32'd7, 5'd5, 32'hDEAD); cycle();
      quiet(); repeat (3) cycle();
      m_done = 1; m_result = 32'd42; cycle();
      m_done = 0; repeat (2) cycle();

      // Timeout, never any m_done
      op(1, 32'd3, 32'd9, 5'd7, 0); cycle();
      quiet(); repeat (9) cycle();

      // Flush in M_WAIT followed by late m_done
      op(1, 32'd1, 32'd2, 5'd8, 0); cycle();
      quiet(); repeat (2) cycle();
      flush = 1; cycle();
      flush = 0; m_done = 1; m_result = 32'h55; cycle();
      m_done = 0; repeat (2) cycle();

      // Flush with the slot full
      out_ready = 0;
      op(0, 0, 0, 5'd9, 32'h77); cycle();
      quiet(); cycle();
      flush = 1; cycle();
      flush = 0; out_ready = 1; repeat (2) cycle();

      // Reset in M_WAIT, then a fresh ALU op
      op(1, 32'd4, 32'd5, 5'd10, 0); cycle();
      quiet(); repeat (2) cycle();
      rst = 1; cycle();
      rst = 0; op(0, 0, 0, 5'd11, 32'h99); cycle();
      quiet(); repeat (2) cycle();

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         rst        = ($urandom_range(0, 299) == 0);
         flush      = ($urandom_range(0, 19) == 0);
         in_valid   = $urandom_range(0, 1);
         in_is_mul  = ($urandom_range(0, 2) == 0);
         in_func3   = 3'($urandom);
         in_op1     = $urandom;
         in_op2     = $urandom;
         in_dst     = RW'($urandom);
         alu_result = $urandom;
         m_done     = ($urandom_range(0, 3) == 0);
         m_result   = $urandom;
         out_ready  = ($urandom_range(0, 3) != 0);
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
